// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter, MSB first, with repeats and gaps.
// Optional even-parity bit after each frame when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_len,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

`ifdef SEQ_TX_PARITY_EN
  localparam int FRAME_W = PAT_W + 1;
`else
  localparam int FRAME_W = PAT_W;
`endif
  localparam int IDX_W = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    GAP    = 2'b10,
    FINISH = 2'b11
  } state_t;

  state_t st_q, st_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRAME_W-1:0] frame;

  // Frame as sent: pattern bits, then the parity slot at index 0 if enabled.
`ifdef SEQ_TX_PARITY_EN
  assign frame = {pat_q, ^pat_q};
`else
  assign frame = pat_q;
`endif

  // State and working registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      pat_q  <= '0;
      reps_q <= '0;
      gap_q  <= '0;
      gcnt_q <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      pat_q  <= pat_d;
      reps_q <= reps_d;
      gap_q  <= gap_d;
      gcnt_q <= gcnt_d;
      idx_q  <= idx_d;
    end
  end

  // Next-state: walk bits, then repeat, insert gap, or finish.
  always_comb begin
    st_d   = st_q;
    pat_d  = pat_q;
    reps_d = reps_q;
    gap_d  = gap_q;
    gcnt_d = gcnt_q;
    idx_d  = idx_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          pat_d  = pattern;
          reps_d = repeat_n;
          gap_d  = gap_len;
          gcnt_d = '0;
          idx_d  = IDX_LAST;
          st_d   = SEND;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (reps_q == '0) begin
          st_d = FINISH;
        end else begin
          reps_d = reps_q - CNT_W'(1);
          idx_d  = IDX_LAST;
          if (gap_q != '0) begin
            gcnt_d = gap_q - GAP_W'(1);
            st_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end else begin
          idx_d = IDX_LAST;
          st_d  = SEND;
        end
      end
      FINISH: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  assign state    = st_q;
  assign tx_valid = (st_q == SEND);
  assign tx_bit   = tx_valid & frame[idx_q];
  assign busy     = (st_q != IDLE);
  assign done     = (st_q == FINISH);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed and randomized checks of seq_pattern_tx.
// Expected per-cycle outputs come from a frame-list model built in the bench.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;
`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             tx_bit;
  logic             tx_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;

  // expected {tx_valid, tx_bit, busy, done, state} per cycle after accept
  logic [5:0] exp_q[$];

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pattern(pattern),
    .repeat_n(repeat_n),
    .gap_len(gap_len),
    .tx_bit(tx_bit),
    .tx_valid(tx_valid),
    .busy(busy),
    .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {tx_valid, tx_bit, busy, done, state};
  endfunction

  // Model: list the frames, bit by bit, then gaps, done, one idle cycle.
  task automatic build_exp(input logic [PAT_W-1:0] p,
                           input int r, input int g);
    exp_q.delete();
    for (int f = 0; f <= r; f++) begin
      for (int k = PAT_W - 1; k >= 0; k--)
        exp_q.push_back({1'b1, p[k], 1'b1, 1'b0, 2'b01});
      if (PAR) exp_q.push_back({1'b1, ^p, 1'b1, 1'b0, 2'b01});
      if (f < r)
        for (int j = 0; j < g; j++)
          exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 2'b10});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 2'b11});
    exp_q.push_back(6'b000000);
  endtask

  // Present a one-cycle start, then scramble inputs; ends in cycle 1.
  task automatic do_start(input logic [PAT_W-1:0] p,
                          input int r, input int g);
    @(negedge clk);
    start    = 1'b1;
    pattern  = p;
    repeat_n = CNT_W'(r);
    gap_len  = GAP_W'(g);
    @(negedge clk);
    start    = 1'b0;
    pattern  = PAT_W'($urandom);
    repeat_n = CNT_W'($urandom);
    gap_len  = GAP_W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== 6'b000000) begin
        errors++;
        $display("FAIL reset cyc%0d got %b want 000000", i, obs());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    build_exp(4'b1010, 0, 0);
    do_start(4'b1010, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL single cyc%0d got %b want %b", i + 1, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    build_exp(4'b1010, 1, 2);
    do_start(4'b1010, 1, 2);
    foreach (exp_q[i]) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL gap cyc%0d got %b want %b", i + 1, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  // Back-to-back frames feed an overlapping "1010" detector; start is held
  // high through FINISH and must be taken on the first IDLE edge.
  task automatic test_back_to_back();
    logic [3:0] sh_dut;
    logic [3:0] sh_exp;
    int hits_dut;
    int hits_exp;
    sh_dut = '0;
    sh_exp = '0;
    hits_dut = 0;
    hits_exp = 0;
    build_exp(4'b1010, 1, 0);
    @(negedge clk);
    start = 1'b1;
    pattern = 4'b1010;
    repeat_n = 4'd1;
    gap_len = 4'd0;
    @(negedge clk);
    foreach (exp_q[i]) begin
      if (i < exp_q.size() - 1) begin
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b cyc%0d got %b want %b", i + 1, obs(), exp_q[i]);
        end
        if (tx_valid) begin
          sh_dut = {sh_dut[2:0], tx_bit};
          if (sh_dut == 4'b1010) hits_dut++;
        end
        if (exp_q[i][5]) begin
          sh_exp = {sh_exp[2:0], exp_q[i][4]};
          if (sh_exp == 4'b1010) hits_exp++;
        end
      end else begin
        checks++;
        if (state !== 2'b00 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle got state=%b busy=%b want 00/0", state, busy);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1 || state !== 2'b01) begin
      errors++;
      $display("FAIL b2b_restart got v=%b b=%b s=%b want 1/1/01",
               tx_valid, tx_bit, state);
    end
    checks++;
    if (hits_dut != hits_exp) begin
      errors++;
      $display("FAIL b2b_detect got %0d want %0d", hits_dut, hits_exp);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ignore_start();
    build_exp(4'b1010, 0, 0);
    do_start(4'b1010, 0, 0);
    foreach (exp_q[i]) begin
      start   = (i == 1 || i == exp_q.size() - 2);
      pattern = 4'b1111;
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore cyc%0d got %b want %b", i + 1, obs(), exp_q[i]);
      end
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int seen_done;
    seen_done = 0;
    build_exp(4'b1010, 0, 0);
    do_start(4'b1010, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 6'b000000) begin
      errors++;
      $display("FAIL midreset got %b want 000000", obs());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL midreset_done got %0d pulses want 0", seen_done);
    end
    do_start(4'b1010, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL postreset cyc%0d got %b want %b", i + 1, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random(input int n);
    logic [PAT_W-1:0] p;
    int r;
    int g;
    for (int t = 0; t < n; t++) begin
      p = PAT_W'($urandom);
      r = $urandom_range(0, 3);
      g = $urandom_range(0, 3);
      if (t == n - 1) begin
        r = (1 << CNT_W) - 1;
        g = (1 << GAP_W) - 1;
      end
      build_exp(p, r, g);
      do_start(p, r, g);
      foreach (exp_q[i]) begin
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL rand t%0d p=%b r=%0d g=%0d cyc%0d got %b want %b",
                   t, p, r, g, i + 1, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_ignore_start();
    test_reset_midframe();
    test_random(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Bit-serial pattern transmitter. Emits a programmable PAT_W-bit pattern MSB-first on a single serial line, repeated a programmable number of times with optional idle gaps between repetitions. It is the stimulus/transmit end of the serial bit-sequence detectors in this codebase: PAT_W=4, pattern 4'b1010 drives the "1010" detectors directly.

## Interface
Parameters:
- PAT_W, 4, pattern width in bits (>=2)
- CNT_W, 4, width of repeat_n
- GAP_W, 4, width of gap_len

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- pattern  input  PAT_W  pattern to send, MSB first; latched on accepted start
- repeat_n  input  CNT_W  extra repetitions; frames sent = repeat_n+1; latched on accepted start
- gap_len  input  GAP_W  idle cycles between frames; latched on accepted start
- tx_bit  output  1  serial data; 0 whenever tx_valid=0
- tx_valid  output  1  tx_bit carries a frame bit this cycle
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the final bit of the last frame
- state  output  2  current FSM state, for debug

## Operation
- FSM, encoding: IDLE=2'b00, SEND=2'b01, GAP=2'b10, FINISH=2'b11.
- Internal registers: pat_q[PAT_W-1:0], reps_q[CNT_W-1:0], gap_q[GAP_W-1:0], bit index idx, gap counter gcnt.
- IDLE: tx_valid=0, tx_bit=0. start=1 at an edge: latch pattern/repeat_n/gap_len, idx=FRAME_W-1, go to SEND. start=0: stay.
- SEND: tx_valid=1, tx_bit=pat_q[idx] (parity bit in parity slot, see Configuration). Each edge: idx>0 -> idx-1. At last bit of frame:
  - reps_q==0 -> FINISH.
  - reps_q>0, gap_q==0 -> reps_q-1, reload idx, stay in SEND (frames back-to-back).
  - reps_q>0, gap_q>0 -> reps_q-1, gcnt=gap_q-1, go to GAP.
- GAP: tx_valid=0, tx_bit=0. gcnt>0 -> decrement; gcnt==0 -> reload idx, go to SEND.
- FINISH: done=1, tx_valid=0, busy=1; next edge -> IDLE unconditionally.
- start outside IDLE ignored (including FINISH); input changes after acceptance have no effect.
- Async reset: all state to IDLE, internal registers 0, all outputs 0 immediately; a frame in progress is abandoned with no done.

## Timing
- All outputs registered or decoded from registered state only; no combinational path from any input to any output.
- start accepted at edge E0: first bit (pattern MSB) valid in the cycle after E0.
- FRAME_W = PAT_W (PAT_W+1 with parity). Total SEND cycles (R+1)*FRAME_W, GAP cycles R*G, where R=repeat_n, G=gap_len.
- done high during the single cycle after edge E0+(R+1)*FRAME_W+R*G; IDLE on the following edge; earliest next start accepted at that IDLE edge+1 cycle (i.e., start held high through FINISH is accepted on the first edge in IDLE).
- busy high from after E0 through the done cycle inclusive.
- Maximum values (R=2^CNT_W-1, G=2^GAP_W-1) must not wrap counters.

## Configuration
- SEQ_TX_PARITY_EN defined: each frame is followed by one even-parity bit (XOR of pat_q) with tx_valid=1; FRAME_W=PAT_W+1; gap/repeat logic applies after the parity bit.
- Undefined: no parity bit; FRAME_W=PAT_W.

## Test plan
- Reset held 2 cycles, then released with start=0 -> tx_bit=0, tx_valid=0, busy=0, done=0, state=2'b00 throughout.
- pattern=4'b1010, repeat_n=0, gap_len=0, start pulse -> tx_bit 1,0,1,0 with tx_valid=1 for 4 cycles, then done=1 for 1 cycle, busy high 5 cycles, state back to 2'b00.
- pattern=4'b1010, repeat_n=1, gap_len=2 -> 1,0,1,0, two cycles tx_valid=0, 1,0,1,0, done on cycle 11; same with gap_len=0 -> 8 contiguous bits 10101010, done on cycle 9, and an overlapping "1010" detector fed tx_bit fires 3 times.
- start re-pulsed with pattern=4'b1111 during bit 2 of a 4'b1010 frame -> ignored; output remains 1,0,1,0, single done.
- reset asserted mid-frame (after 2nd bit) -> tx_valid, tx_bit, busy drop to 0 without waiting for clk; no done pulse; next start after release sends a full frame.
- With SEQ_TX_PARITY_EN, pattern=4'b1011 -> 1,0,1,1,1 (parity=1), done on cycle 6; pattern=4'b1010 -> 1,0,1,0,0.
